// File: rtl/plic_lite.sv
// plic_lite: minimal platform-level interrupt controller with a Wishbone slave port.
// Level sources pass a one-register gateway, then get gated by enable, prioritised and
// compared against a threshold to drive a single registered interrupt line to the core.
module plic_lite #(
    parameter int unsigned NUM_SRC      = 8,
    parameter int unsigned PRIO_W       = 3,
    parameter int unsigned WB_AD_WIDTH  = 32,
    parameter int unsigned WB_DAT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        irq_src_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic [WB_AD_WIDTH-1:0]    wbs_addr_i,
    input  logic [WB_DAT_WIDTH-1:0]   wbs_wdata_i,
    input  logic [WB_DAT_WIDTH/8-1:0] wbs_sel_i,
    input  logic                      wbs_we_i,
    output logic [WB_DAT_WIDTH-1:0]   wbs_rdata_o,
    output logic                      wbs_ack_o,
    output logic                      plic_ext_irq_o
);

    localparam int unsigned IdW = $clog2(NUM_SRC + 1);

    localparam logic [7:0] AddrPending = 8'h80;
    localparam logic [7:0] AddrEnable  = 8'h84;
    localparam logic [7:0] AddrThresh  = 8'h88;
    localparam logic [7:0] AddrClaim   = 8'h8C;

    // Per-source state is indexed by source ID (1..NUM_SRC).
    logic [NUM_SRC-1:0]      src_q;
    logic [NUM_SRC:1]        src_ids;
    logic [NUM_SRC:1]        pending_q, pending_d;
    logic [NUM_SRC:1]        in_flight_q, in_flight_d;
    logic [NUM_SRC:1]        enable_q, enable_d;
    logic [PRIO_W-1:0]       prio_q [1:NUM_SRC];
    logic [PRIO_W-1:0]       prio_d [1:NUM_SRC];
    logic [PRIO_W-1:0]       thresh_q, thresh_d;
    logic                    ack_q, ack_d;
    logic [WB_DAT_WIDTH-1:0] rdata_q, rdata_d;
    logic                    irq_q, irq_d;

    logic [IdW-1:0]          best_id;
    logic [PRIO_W-1:0]       best_prio;
    logic [7:0]              addr;
    logic                    accept;
    logic                    rd_acc;
    logic                    wr_acc;
    logic [WB_DAT_WIDTH-1:0] rd_val;

    // Byte select and upper address bits carry no information for this block.
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_addr_i[WB_AD_WIDTH-1:8]};

    assign addr    = wbs_addr_i[7:0];
    assign accept  = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign rd_acc  = accept & ~wbs_we_i;
    assign wr_acc  = accept & wbs_we_i;
    assign src_ids = src_q;

    // Arbiter: highest priority above threshold wins; strict compare keeps the lowest ID on ties.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            if (pending_q[i] && enable_q[i] && (prio_q[i] > thresh_q) &&
                (prio_q[i] > best_prio)) begin
                best_id   = IdW'(i);
                best_prio = prio_q[i];
            end
        end
    end

    // Read mux; unmapped addresses and unused bits read as zero.
    always_comb begin
        rd_val = '0;
        case (addr)
            AddrPending: begin
                for (int unsigned i = 1; i <= NUM_SRC; i++) rd_val[i] = pending_q[i];
            end
            AddrEnable: begin
                for (int unsigned i = 1; i <= NUM_SRC; i++) rd_val[i] = enable_q[i];
            end
            AddrThresh: rd_val[PRIO_W-1:0] = thresh_q;
            AddrClaim:  rd_val[IdW-1:0]    = best_id;
            default: begin
                for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                    if (addr == 8'(4 * i)) rd_val[PRIO_W-1:0] = prio_q[i];
                end
            end
        endcase
    end

    // Gateway, claim/complete and register write next-state.
    always_comb begin
        pending_d   = pending_q | (src_ids & ~pending_q & ~in_flight_q);
        in_flight_d = in_flight_q;
        enable_d    = enable_q;
        thresh_d    = thresh_q;
        prio_d      = prio_q;

        // A claim that returns 0 has no side effect.
        if (rd_acc && (addr == AddrClaim) && (best_id != '0)) begin
            for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                if (best_id == IdW'(i)) begin
                    pending_d[i]   = 1'b0;
                    in_flight_d[i] = 1'b1;
                end
            end
        end

        if (wr_acc) begin
            case (addr)
                AddrEnable: enable_d = wbs_wdata_i[NUM_SRC:1];
                AddrThresh: thresh_d = wbs_wdata_i[PRIO_W-1:0];
                AddrClaim: begin
                    // Full-word match: IDs 0 and > NUM_SRC never hit any source.
                    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                        if (wbs_wdata_i == WB_DAT_WIDTH'(i)) in_flight_d[i] = 1'b0;
                    end
                end
                default: begin
                    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
                        if (addr == 8'(4 * i)) prio_d[i] = wbs_wdata_i[PRIO_W-1:0];
                    end
                end
            endcase
        end
    end

    // Bus response and interrupt line next-state.
    always_comb begin
        ack_d   = accept;
        rdata_d = rdata_q;
        if (accept) rdata_d = wbs_we_i ? '0 : rd_val;
        irq_d   = (best_id != '0);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q       <= '0;
            pending_q   <= '0;
            in_flight_q <= '0;
            enable_q    <= '0;
            thresh_q    <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
            for (int unsigned i = 1; i <= NUM_SRC; i++) prio_q[i] <= '0;
        end else begin
            src_q       <= irq_src_i;
            pending_q   <= pending_d;
            in_flight_q <= in_flight_d;
            enable_q    <= enable_d;
            thresh_q    <= thresh_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
            for (int unsigned i = 1; i <= NUM_SRC; i++) prio_q[i] <= prio_d[i];
        end
    end

    assign wbs_ack_o      = ack_q & wbs_cyc_i;
    assign wbs_rdata_o    = rdata_q;
    assign plic_ext_irq_o = irq_q;

endmodule

// File: tb/tb_plic_lite.sv
// Testbench for plic_lite: register table, directed corner sequences, and a randomized run
// checked cycle by cycle against a behavioural model of the controller.
module tb_plic_lite;

    localparam int N = 8;
    localparam logic [31:0] EnMask = ((32'd1 << (N + 1)) - 32'd1) & ~32'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [N-1:0] irq_src = '0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] rdata;
    logic        ack;
    logic        ext_irq;

    always #5 clk = ~clk;

    plic_lite #(
        .NUM_SRC(N),
        .PRIO_W(3),
        .WB_AD_WIDTH(32),
        .WB_DAT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq_src_i(irq_src),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_addr_i(addr),
        .wbs_wdata_i(wdata),
        .wbs_sel_i(sel),
        .wbs_we_i(we),
        .wbs_rdata_o(rdata),
        .wbs_ack_o(ack),
        .plic_ext_irq_o(ext_irq)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model: bit ID of each word holds that source's state.
    logic [2:0]  m_prio [0:31];
    logic [31:0] m_en, m_pend, m_infl, m_src, m_rdata;
    logic [2:0]  m_th;
    logic        m_ack, m_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Search priority levels from the top down, IDs from the bottom up.
    function automatic int m_best();
        for (int p = 7; p >= 1; p--) begin
            if (p <= int'(m_th)) return 0;
            for (int id = 1; id <= N; id++) begin
                if (m_pend[id] && m_en[id] && int'(m_prio[id]) == p) return id;
            end
        end
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a, input int b);
        if (a == 8'h80) return m_pend;
        if (a == 8'h84) return m_en;
        if (a == 8'h88) return {29'b0, m_th};
        if (a == 8'h8C) return 32'(b);
        if (a[1:0] == 2'b00 && a >= 8'd4 && int'(a) <= 4 * N) return {29'b0, m_prio[a >> 2]};
        return 32'h0;
    endfunction

    // One clock: advance the model from pre-edge inputs, then compare just after the edge.
    task automatic tick();
        logic [31:0] n_pend, n_infl, n_rd;
        logic [7:0]  a;
        logic        acc;
        logic        n_irq;
        int          b;
        a = addr[7:0];
        if (rst) begin
            for (int i = 0; i < 32; i++) m_prio[i] = 3'd0;
            m_en = 0; m_th = 0;
            n_pend = 0; n_infl = 0; n_rd = 0; n_irq = 0; acc = 0;
        end else begin
            b      = m_best();
            acc    = cyc & stb & ~m_ack;
            n_pend = m_pend | (m_src & ~m_pend & ~m_infl);
            n_infl = m_infl;
            n_rd   = m_rdata;
            n_irq  = (b != 0);
            if (acc) n_rd = we ? 32'h0 : m_read(a, b);
            if (acc && !we && a == 8'h8C && b != 0) begin
                n_pend[b] = 1'b0;
                n_infl[b] = 1'b1;
            end
            if (acc && we) begin
                if (a == 8'h84) m_en = wdata & EnMask;
                else if (a == 8'h88) m_th = wdata[2:0];
                else if (a == 8'h8C) begin
                    if (wdata >= 1 && wdata <= N && m_infl[wdata]) n_infl[wdata] = 1'b0;
                end else if (a[1:0] == 2'b00 && a >= 8'd4 && int'(a) <= 4 * N)
                    m_prio[a >> 2] = wdata[2:0];
            end
        end
        m_src = rst ? 32'h0 : (32'(irq_src) << 1);
        @(posedge clk);
        #1;
        m_pend = n_pend; m_infl = n_infl; m_rdata = n_rd; m_ack = acc; m_irq = n_irq;
        check("irq_model", {31'b0, ext_irq}, {31'b0, m_irq});
        check("ack_model", {31'b0, ack}, {31'b0, m_ack & cyc});
    endtask

    task automatic wb_access(input logic [7:0] a, input logic w, input logic [31:0] d,
                             output logic [31:0] r);
        logic got;
        cyc = 1'b1; stb = 1'b1; we = w; addr = {24'h0, a}; wdata = d;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            tick();
            if (ack) got = 1'b1;
        end
        check("ack_timeout", {31'b0, got}, 32'h1);
        r = rdata;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r;
        wb_access(a, 1'b1, d, r);
    endtask

    task automatic rdc(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_access(a, 1'b0, 32'h0, r);
        check(name, r, exp);
    endtask

    task automatic rdm(input logic [7:0] a);
        logic [31:0] r;
        wb_access(a, 1'b0, 32'h0, r);
        check("rdata_model", r, m_rdata);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        logic [7:0]  a;
        logic        w;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [$];

    initial begin
        logic [31:0] r;
        for (int i = 0; i < 32; i++) m_prio[i] = 3'd0;
        m_en = 0; m_pend = 0; m_infl = 0; m_src = 0; m_rdata = 0; m_th = 0;
        m_ack = 0; m_irq = 0;

        tbl.push_back('{8'h04, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{8'h20, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{8'h80, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{8'h84, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{8'h88, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{8'h8C, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{8'h0C, 1'b1, 32'h5, 32'h0});
        tbl.push_back('{8'h84, 1'b1, 32'h1E, 32'h0});
        tbl.push_back('{8'h88, 1'b1, 32'h2, 32'h0});
        tbl.push_back('{8'h0C, 1'b0, 32'h0, 32'h5});
        tbl.push_back('{8'h84, 1'b0, 32'h0, 32'h1E});
        tbl.push_back('{8'h88, 1'b0, 32'h0, 32'h2});
        tbl.push_back('{8'h20, 1'b1, 32'hFF, 32'h0});
        tbl.push_back('{8'h20, 1'b0, 32'h0, 32'h7});
        tbl.push_back('{8'h84, 1'b1, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{8'h84, 1'b0, 32'h0, 32'h1FE});
        tbl.push_back('{8'h88, 1'b1, 32'hF, 32'h0});
        tbl.push_back('{8'h88, 1'b0, 32'h0, 32'h7});
        tbl.push_back('{8'h00, 1'b1, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{8'h00, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{8'hF0, 1'b1, 32'h1, 32'h0});
        tbl.push_back('{8'hF0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{8'h24, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{8'h0C, 1'b1, 32'h0, 32'h0});
        tbl.push_back('{8'h20, 1'b1, 32'h0, 32'h0});
        tbl.push_back('{8'h84, 1'b1, 32'h0, 32'h0});
        tbl.push_back('{8'h88, 1'b1, 32'h0, 32'h0});
        tbl.push_back('{8'h84, 1'b0, 32'h0, 32'h0});

        // Reset
        ticks(3);
        rst = 1'b0;
        check("reset_irq", {31'b0, ext_irq}, 32'h0);
        check("reset_ack", {31'b0, ack}, 32'h0);
        check("reset_rdata", rdata, 32'h0);

        foreach (tbl[i]) begin
            wb_access(tbl[i].a, tbl[i].w, tbl[i].d, r);
            if (!tbl[i].w) check($sformatf("tbl%0d_addr%0h", i, tbl[i].a), r, tbl[i].exp);
        end

        // Single source latency, claim, hold-off until complete
        wr(8'h04, 32'd1); wr(8'h84, 32'h2); wr(8'h88, 32'h0);
        irq_src = 8'h01;
        tick(); check("lat_n", {31'b0, ext_irq}, 32'h0);
        tick(); check("lat_n1", {31'b0, ext_irq}, 32'h0);
        tick(); check("lat_n2", {31'b0, ext_irq}, 32'h1);
        rdc("claim_single", 8'h8C, 32'd1);
        tick(); check("irq_after_claim", {31'b0, ext_irq}, 32'h0);
        rdc("pending_after_claim", 8'h80, 32'h0);
        ticks(4); check("no_repend_held", {31'b0, ext_irq}, 32'h0);
        wr(8'h8C, 32'd1);
        tick(); check("complete_c1", {31'b0, ext_irq}, 32'h0);
        tick(); check("complete_c2", {31'b0, ext_irq}, 32'h1);
        irq_src = 8'h00;
        rdc("claim_again", 8'h8C, 32'd1);
        wr(8'h8C, 32'd1);
        ticks(2); check("idle_after_complete", {31'b0, ext_irq}, 32'h0);

        // Priority and tie-break
        wr(8'h08, 32'd4); wr(8'h0C, 32'd4); wr(8'h10, 32'd4); wr(8'h84, 32'h1C);
        irq_src = 8'h0E;
        ticks(3);
        rdc("claim_tie", 8'h8C, 32'd2);
        wr(8'h10, 32'd6);
        rdc("claim_prio", 8'h8C, 32'd4);
        rdc("claim_last", 8'h8C, 32'd3);
        irq_src = 8'h00;
        wr(8'h8C, 32'd2); wr(8'h8C, 32'd3); wr(8'h8C, 32'd4);
        rdc("claim_none", 8'h8C, 32'd0);
        rdc("pending_none", 8'h80, 32'h0);

        // Threshold blocks priority equal to it
        wr(8'h04, 32'd2); wr(8'h88, 32'd2); wr(8'h84, 32'h2);
        irq_src = 8'h01;
        ticks(3); check("thresh_block", {31'b0, ext_irq}, 32'h0);
        rdc("claim_below_thresh", 8'h8C, 32'd0);
        rdc("pending_kept", 8'h80, 32'h2);
        wr(8'h88, 32'd1);
        tick(); check("thresh_lowered", {31'b0, ext_irq}, 32'h1);
        rdc("claim_thresh", 8'h8C, 32'd1);

        // Invalid completes leave source 1 in flight
        wr(8'h8C, 32'd0); wr(8'h8C, 32'd9); wr(8'h8C, 32'd2); wr(8'h8C, 32'h101);
        rdc("invalid_complete", 8'h80, 32'h0);
        tick(); check("invalid_no_irq", {31'b0, ext_irq}, 32'h0);
        wr(8'h8C, 32'd1);
        ticks(2); check("valid_complete", {31'b0, ext_irq}, 32'h1);

        // Reset in the middle of an access
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h8C;
        rst = 1'b1;
        tick(); check("rst_ack0", {31'b0, ack}, 32'h0);
        tick(); check("rst_ack1", {31'b0, ack}, 32'h0);
        check("rst_irq", {31'b0, ext_irq}, 32'h0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        ticks(3); check("no_irq_after_rst", {31'b0, ext_irq}, 32'h0);
        rdc("rst_enable", 8'h84, 32'h0);
        rdc("rst_prio1", 8'h04, 32'h0);
        rdc("rst_thresh", 8'h88, 32'h0);
        rdm(8'h80);
        wr(8'h04, 32'd1); wr(8'h84, 32'h2);
        tick(); check("reenable_irq", {31'b0, ext_irq}, 32'h1);
        rdc("claim_reenable", 8'h8C, 32'd1);
        irq_src = 8'h00;
        wr(8'h8C, 32'd1);

        // Randomized traffic against the model
        for (int it = 0; it < 1500; it++) begin
            int op;
            if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
            op = $urandom_range(0, 9);
            case (op)
                0: wr(8'(4 * $urandom_range(1, N)), 32'($urandom_range(0, 7)));
                1: wr(8'h84, $urandom);
                2: wr(8'h88, 32'($urandom_range(0, 3)));
                3, 4: rdm(8'h8C);
                5: wr(8'h8C, 32'($urandom_range(0, 10)));
                6: rdm(8'h80);
                7: rdm(8'(4 * $urandom_range(0, N + 1)));
                8: begin
                    if ($urandom_range(0, 30) == 0) begin
                        rst = 1'b1; tick(); rst = 1'b0;
                    end else begin
                        tick();
                    end
                end
                default: tick();
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
